cpu_trace_buffer: RTL and testbench
===================================

Name: cpu_trace_buffer

Overview:
- Downstream consumer of the debug_signals_t bundle produced by the CPU debug aggregation module.
- Captures one packed 96-bit trace record per cycle in which the CPU sits in a selectable execution state, into a circular buffer.
- Supports arm / trigger / post-trigger / freeze.
- Drains the frozen buffer oldest-first as 16-bit words over a valid/ready stream, e.g. toward a UART bridge.

Parameters:
- DEPTH, 16, record slots; power of two, >= 2.
- POST_TRIG, 4, qualifying records captured after the trigger before freezing; 0..DEPTH-1.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- debug_in  in  debug_signals_t  CPU debug bundle, sampled each clk.
- cap_state  in  EXECUTION_STATES  state that qualifies a capture.
- arm  in  1  pulse; IDLE -> ARMED.
- trig  in  1  pulse; starts the post-trigger countdown.
- stop  in  1  pulse; immediate freeze.
- rd_start  in  1  pulse; FROZEN -> DUMP.
- dout  out  16  stream word.
- dout_valid  out  1  word valid.
- dout_ready  in  1  sink accepts.
- dout_last  out  1  final word of the dump.
- tb_state  out  3  TB_STATE encoding.
- rec_count  out  $clog2(DEPTH)+1  records held, saturating at DEPTH.
- overflow  out  1  sticky; an old record was overwritten since arm.

Behaviour:
- Reset: all outputs 0 (tb_state = IDLE), pointers/counters 0, cycle stamp 0. No memory clear needed.
- Cycle stamp: 16-bit free-running counter, +1 every clk in every state, wraps 0xFFFF -> 0.
- qualify = (tb_state == ARMED or TRIGGERED) && debug_in.exec_state == cap_state.
- Record words:
  - W0 = stamp.
  - W1 = {exec_state[3:0], macro_op[2:0], alu_func[3:0], status[3:0], 1'b0}.
  - W2 = alu_in_a.
  - W3 = alu_in_b.
  - W4 = alu_out.
  - W5 = {dst_reg[4:0], reg_wr[1:0], branch_cond[3:0], fetch_done, status_wr, pc_branch_wr, 2'b00}.
- Write: on qualify, the record is written at wr_ptr and wr_ptr increments mod DEPTH. One write per cycle maximum.
  - If rec_count == DEPTH: the oldest record is overwritten, rd_ptr advances with wr_ptr, overflow is set.
  - Otherwise rec_count increments.
- FSM (TB_STATE): IDLE, ARMED, TRIGGERED, FROZEN, DUMP.
  - IDLE + arm -> ARMED. Clears wr_ptr, rd_ptr, rec_count, overflow.
  - ARMED + trig -> TRIGGERED; post counter := POST_TRIG. A capture in the trig cycle itself is stored but not counted. If POST_TRIG == 0, go straight to FROZEN instead.
  - TRIGGERED: each qualify decrements the post counter. The decrement from 1 to 0 stores that record and moves to FROZEN the next cycle.
  - ARMED or TRIGGERED + stop -> FROZEN. A capture in the stop cycle is still stored. stop has priority over trig.
  - FROZEN + rd_start:
    - rec_count > 0 -> DUMP.
    - rec_count == 0 -> IDLE, no words emitted.
  - DUMP: emits rec_count x 6 words, oldest record first, W0..W5 order.
    - A word advances only on dout_valid && dout_ready.
    - dout_valid rises the cycle after DUMP entry, then is held while words remain.
    - dout and dout_valid are registered and stable while ready is low.
    - dout_last is high only with W5 of the last record.
    - After the last handshake -> IDLE with dout_valid = 0. rec_count is zeroed.
- Ignored inputs:
  - arm outside IDLE.
  - trig outside ARMED; a second trig is ignored.
  - stop in IDLE, FROZEN or DUMP.
  - rd_start outside FROZEN.
- Any rst_n assertion, including mid-DUMP, aborts immediately to reset values. No partial word is held.

Decomposition:
- Shared debug package gains:
  - TB_STATE enum (logic[2:0]: IDLE, ARMED, TRIGGERED, FROZEN, DUMP).
  - TRACE_WORDS = 6 constant.
  - trace_rec_t packed struct (six 16-bit words).
- One sub-module, trace_ram: a DEPTH x 96 simple dual-port RAM.
  - Synchronous write.
  - Registered read with 1-cycle latency, absorbed by the dout_valid startup cycle.

Test Plan:
- Basic capture: arm, cap_state = WRITE_BACK, drive 3 WRITE_BACK cycles with alu_out = 0x1111/0x2222/0x3333, then stop, then rd_start with ready = 1. Expect 18 words; W4 values 0x1111, 0x2222, 0x3333 in order; dout_last on word 18; ends in IDLE; rec_count = 0.
- Wrap with DEPTH = 16: capture 20 records with alu_out = 1..20, then stop. Expect rec_count = 16, overflow = 1; dump W4 sequence 5..20.
- Trigger, POST_TRIG = 4: 10 qualifying cycles, trig asserted on cycle 6. Expect FROZEN after cycle 10; rec_count = 10; further qualifying cycles not stored.
- Backpressure: during dump, toggle dout_ready 1-0-0-1 randomly. Expect no dropped or duplicated words; dout stable while ready = 0; W0 stamps strictly increasing.
- Empty / ignored inputs: arm then stop with no qualifying cycles, then rd_start. Expect no dout_valid and a return to IDLE. trig in IDLE leaves tb_state = IDLE.
- Reset mid-dump: assert rst_n = 0 after word 7. Expect dout_valid = 0 and tb_state = IDLE asynchronously; stamp = 0 after release.

Source files
------------

// File: rtl/cpu_trace_buffer_pkg.sv
// Shared debug types for the CPU trace buffer.
// Holds the CPU debug bundle, the execution-state enum, the trace FSM encoding,
// the 96-bit trace record layout and the helpers that pack and unpack it.
package cpu_trace_buffer_pkg;

    localparam int unsigned TRACE_WORDS = 6;
    localparam int unsigned WORD_W      = 16;
    localparam int unsigned REC_W       = TRACE_WORDS * WORD_W;

    typedef enum logic [3:0] {
        FETCH      = 4'd0,
        DECODE     = 4'd1,
        EXECUTE    = 4'd2,
        MEM_ACCESS = 4'd3,
        WRITE_BACK = 4'd4,
        INTERRUPT  = 4'd5,
        HALT       = 4'd6
    } EXECUTION_STATES;

    typedef struct packed {
        EXECUTION_STATES exec_state;
        logic [2:0]      macro_op;
        logic [3:0]      alu_func;
        logic [3:0]      status;
        logic [15:0]     alu_in_a;
        logic [15:0]     alu_in_b;
        logic [15:0]     alu_out;
        logic [4:0]      dst_reg;
        logic [1:0]      reg_wr;
        logic [3:0]      branch_cond;
        logic            fetch_done;
        logic            status_wr;
        logic            pc_branch_wr;
    } debug_signals_t;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ARMED     = 3'd1,
        TRIGGERED = 3'd2,
        FROZEN    = 3'd3,
        DUMP      = 3'd4
    } TB_STATE;

    // w0 is the first word streamed out for a record
    typedef struct packed {
        logic [15:0] w0;
        logic [15:0] w1;
        logic [15:0] w2;
        logic [15:0] w3;
        logic [15:0] w4;
        logic [15:0] w5;
    } trace_rec_t;

    // Build one trace record from the debug bundle and the current cycle stamp.
    function automatic trace_rec_t pack_record(input debug_signals_t d,
                                               input logic [15:0]    stamp);
        trace_rec_t r;
        r.w0 = stamp;
        r.w1 = {d.exec_state, d.macro_op, d.alu_func, d.status, 1'b0};
        r.w2 = d.alu_in_a;
        r.w3 = d.alu_in_b;
        r.w4 = d.alu_out;
        r.w5 = {d.dst_reg, d.reg_wr, d.branch_cond, d.fetch_done,
                d.status_wr, d.pc_branch_wr, 2'b00};
        return r;
    endfunction

    // Select word idx (0..5) of a record.
    function automatic logic [15:0] rec_word(input trace_rec_t r,
                                             input logic [2:0] idx);
        logic [15:0] w;
        case (idx)
            3'd0:    w = r.w0;
            3'd1:    w = r.w1;
            3'd2:    w = r.w2;
            3'd3:    w = r.w3;
            3'd4:    w = r.w4;
            default: w = r.w5;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/cpu_trace_buffer_trace_ram.sv
// Simple dual-port record store for the trace buffer.
// Ports: clk; we/waddr/wdata synchronous write port; raddr/rdata read port
// with one cycle of registered latency. Contents are not reset.
module trace_ram
    import cpu_trace_buffer_pkg::*;
#(
    parameter  int unsigned DEPTH = 16,
    localparam int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  trace_rec_t    wdata,
    input  logic [AW-1:0] raddr,
    output trace_rec_t    rdata
);

    trace_rec_t mem [DEPTH];
    trace_rec_t rdata_q;

    // Write port
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Registered read port
    always_ff @(posedge clk) begin
        rdata_q <= mem[raddr];
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/cpu_trace_buffer.sv
// CPU trace buffer: captures one 96-bit record per cycle in which the CPU is
// in cap_state into a circular buffer, with arm/trigger/post-trigger/freeze
// control, then drains the frozen buffer oldest-first as 16-bit words.
// Ports: clk, rst_n (async, active low); debug_in/cap_state capture inputs;
// arm/trig/stop/rd_start control pulses; dout/dout_valid/dout_ready/dout_last
// word stream; tb_state, rec_count, overflow status.
module cpu_trace_buffer
    import cpu_trace_buffer_pkg::*;
#(
    parameter  int unsigned DEPTH     = 16,
    parameter  int unsigned POST_TRIG = 4,
    localparam int unsigned AW        = $clog2(DEPTH),
    localparam int unsigned CW        = $clog2(DEPTH) + 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  debug_signals_t  debug_in,
    input  EXECUTION_STATES cap_state,
    input  logic            arm,
    input  logic            trig,
    input  logic            stop,
    input  logic            rd_start,
    output logic [15:0]     dout,
    output logic            dout_valid,
    input  logic            dout_ready,
    output logic            dout_last,
    output logic [2:0]      tb_state,
    output logic [CW-1:0]   rec_count,
    output logic            overflow
);

    localparam logic [2:0] LAST_WORD = 3'(TRACE_WORDS - 1);

    TB_STATE       state_q,     state_d;
    logic [AW-1:0] wr_ptr_q,    wr_ptr_d;
    logic [AW-1:0] rd_ptr_q,    rd_ptr_d;
    logic [CW-1:0] rec_count_q, rec_count_d;
    logic          overflow_q,  overflow_d;
    logic [15:0]   stamp_q,     stamp_d;
    logic [AW-1:0] post_cnt_q,  post_cnt_d;
    logic [CW-1:0] dump_left_q, dump_left_d;
    logic [2:0]    word_q,      word_d;
    logic [15:0]   dout_q,      dout_d;
    logic          dout_valid_q, dout_valid_d;
    logic          dout_last_q,  dout_last_d;

    logic          qualify_c;
    logic          load_c;
    trace_rec_t    wrec_c;
    trace_rec_t    ram_rdata;

    assign wrec_c = pack_record(debug_in, stamp_q);

    // The read address is the next-cycle read pointer, so the record following
    // the one being streamed is already in ram_rdata when its W0 is loaded.
    trace_ram #(
        .DEPTH (DEPTH)
    ) u_ram (
        .clk   (clk),
        .we    (qualify_c),
        .waddr (wr_ptr_q),
        .wdata (wrec_c),
        .raddr (rd_ptr_d),
        .rdata (ram_rdata)
    );

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            rec_count_q  <= '0;
            overflow_q   <= 1'b0;
            stamp_q      <= '0;
            post_cnt_q   <= '0;
            dump_left_q  <= '0;
            word_q       <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            dout_last_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            rec_count_q  <= rec_count_d;
            overflow_q   <= overflow_d;
            stamp_q      <= stamp_d;
            post_cnt_q   <= post_cnt_d;
            dump_left_q  <= dump_left_d;
            word_q       <= word_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            dout_last_q  <= dout_last_d;
        end
    end

    // Capture, control FSM and dump sequencing
    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        rec_count_d  = rec_count_q;
        overflow_d   = overflow_q;
        stamp_d      = stamp_q + 16'd1;
        post_cnt_d   = post_cnt_q;
        dump_left_d  = dump_left_q;
        word_d       = word_q;
        dout_d       = dout_q;
        dout_valid_d = dout_valid_q;
        dout_last_d  = dout_last_q;
        load_c       = 1'b0;

        qualify_c = ((state_q == ARMED) || (state_q == TRIGGERED)) &&
                    (debug_in.exec_state == cap_state);

        // A full buffer drops its oldest record by dragging rd_ptr along.
        if (qualify_c) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
            if (rec_count_q == CW'(DEPTH)) begin
                rd_ptr_d   = rd_ptr_q + AW'(1);
                overflow_d = 1'b1;
            end else begin
                rec_count_d = rec_count_q + CW'(1);
            end
        end

        case (state_q)
            IDLE: begin
                if (arm) begin
                    state_d     = ARMED;
                    wr_ptr_d    = '0;
                    rd_ptr_d    = '0;
                    rec_count_d = '0;
                    overflow_d  = 1'b0;
                end
            end

            ARMED: begin
                if (stop) begin
                    state_d = FROZEN;
                end else if (trig) begin
                    post_cnt_d = AW'(POST_TRIG);
                    state_d    = (POST_TRIG == 0) ? FROZEN : TRIGGERED;
                end
            end

            TRIGGERED: begin
                if (stop) begin
                    state_d = FROZEN;
                end else if (qualify_c) begin
                    post_cnt_d = post_cnt_q - AW'(1);
                    if (post_cnt_q == AW'(1)) begin
                        state_d = FROZEN;
                    end
                end
            end

            FROZEN: begin
                if (rd_start) begin
                    if (rec_count_q != '0) begin
                        state_d     = DUMP;
                        dump_left_d = rec_count_q;
                        word_d      = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end

            DUMP: begin
                // Load the next word when the output register is empty or
                // being accepted this cycle.
                load_c = (dump_left_q != '0) && (!dout_valid_q || dout_ready);
                if (load_c) begin
                    dout_d       = rec_word(ram_rdata, word_q);
                    dout_valid_d = 1'b1;
                    dout_last_d  = 1'b0;
                    if (word_q == LAST_WORD) begin
                        word_d      = '0;
                        rd_ptr_d    = rd_ptr_q + AW'(1);
                        dump_left_d = dump_left_q - CW'(1);
                        dout_last_d = (dump_left_q == CW'(1));
                    end else begin
                        word_d = word_q + 3'd1;
                    end
                end else if (dout_valid_q && dout_ready) begin
                    // Final word accepted
                    dout_d       = '0;
                    dout_valid_d = 1'b0;
                    dout_last_d  = 1'b0;
                    rec_count_d  = '0;
                    state_d      = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign dout_last  = dout_last_q;
    assign tb_state   = state_q;
    assign rec_count  = rec_count_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_cpu_trace_buffer.sv
// Self-checking bench for cpu_trace_buffer: a queue-based reference model is
// compared against the DUT every cycle, plus literal expectations per scenario.
module tb_cpu_trace_buffer;
    import cpu_trace_buffer_pkg::*;

    localparam int unsigned DEPTH     = 16;
    localparam int unsigned POST_TRIG = 4;

    logic            clk = 1'b0;
    logic            rst_n;
    debug_signals_t  debug_in;
    EXECUTION_STATES cap_state;
    logic            arm, trig, stop, rd_start, dout_ready;
    logic [15:0]     dout;
    logic            dout_valid, dout_last, overflow;
    logic [2:0]      tb_state;
    logic [4:0]      rec_count;

    cpu_trace_buffer #(.DEPTH(DEPTH), .POST_TRIG(POST_TRIG)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .debug_in   (debug_in),
        .cap_state  (cap_state),
        .arm        (arm),
        .trig       (trig),
        .stop       (stop),
        .rd_start   (rd_start),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .dout_last  (dout_last),
        .tb_state   (tb_state),
        .rec_count  (rec_count),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    TB_STATE     m_state;
    logic [15:0] m_buf[$];   // stored records, flattened 6 words each, oldest first
    logic [15:0] m_out[$];   // words still to be streamed
    bit          m_valid;
    bit          m_ovf;
    int          m_post;
    logic [15:0] m_stamp;
    bit          m_q;
    logic [15:0] got_w[$];
    bit          got_l[$];
    logic [15:0] smp_dout;
    logic        smp_last;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_state = IDLE;
            m_buf.delete();
            m_out.delete();
            m_valid = 1'b0;
            m_ovf   = 1'b0;
            m_post  = 0;
            m_stamp = 16'd0;
        end else begin
            if (m_valid && dout_ready) begin
                got_w.push_back(smp_dout);
                got_l.push_back(smp_last);
            end
            m_q = ((m_state == ARMED) || (m_state == TRIGGERED)) &&
                  (debug_in.exec_state == cap_state);
            if (m_q) begin
                m_buf.push_back(m_stamp);
                m_buf.push_back({debug_in.exec_state, debug_in.macro_op,
                                 debug_in.alu_func, debug_in.status, 1'b0});
                m_buf.push_back(debug_in.alu_in_a);
                m_buf.push_back(debug_in.alu_in_b);
                m_buf.push_back(debug_in.alu_out);
                m_buf.push_back({debug_in.dst_reg, debug_in.reg_wr, debug_in.branch_cond,
                                 debug_in.fetch_done, debug_in.status_wr,
                                 debug_in.pc_branch_wr, 2'b00});
                if (m_buf.size() > int'(DEPTH) * 6) begin
                    repeat (6) void'(m_buf.pop_front());
                    m_ovf = 1'b1;
                end
            end
            case (m_state)
                IDLE: if (arm) begin
                    m_state = ARMED;
                    m_buf.delete();
                    m_ovf = 1'b0;
                end
                ARMED: if (stop) m_state = FROZEN;
                    else if (trig) begin
                        m_post  = POST_TRIG;
                        m_state = (POST_TRIG == 0) ? FROZEN : TRIGGERED;
                    end
                TRIGGERED: if (stop) m_state = FROZEN;
                    else if (m_q) begin
                        m_post--;
                        if (m_post == 0) m_state = FROZEN;
                    end
                FROZEN: if (rd_start) begin
                    if (m_buf.size() > 0) begin
                        m_state = DUMP;
                        m_out   = m_buf;
                    end else begin
                        m_state = IDLE;
                    end
                end
                DUMP: if (!m_valid) m_valid = 1'b1;
                    else if (dout_ready) begin
                        void'(m_out.pop_front());
                        if (m_out.size() == 0) begin
                            m_valid = 1'b0;
                            m_state = IDLE;
                            m_buf.delete();
                        end
                    end
                default: m_state = IDLE;
            endcase
            m_stamp = m_stamp + 16'd1;
        end
    end

    // Per-cycle compare, sampled just after the active edge
    always @(posedge clk) begin
        #2;
        chk("tb_state", 32'(tb_state), 32'(m_state));
        chk("rec_count", 32'(rec_count), 32'(m_buf.size() / 6));
        chk("overflow", 32'(overflow), 32'(m_ovf));
        chk("dout_valid", 32'(dout_valid), 32'(m_valid));
        if (m_valid) begin
            chk("dout", 32'(dout), 32'(m_out[0]));
            chk("dout_last", 32'(dout_last), 32'(m_out.size() == 1));
        end
        smp_dout = dout;
        smp_last = dout_last;
    end

    // ---------------- stimulus helpers ----------------
    bit rand_ready = 1'b0;

    task automatic dbg_idle();
        debug_in            = '0;
        debug_in.exec_state = FETCH;
    endtask

    task automatic dbg_cap(input logic [15:0] v);
        debug_in.exec_state   = WRITE_BACK;
        debug_in.macro_op     = v[2:0];
        debug_in.alu_func     = v[3:0] ^ 4'h9;
        debug_in.status       = v[7:4];
        debug_in.alu_in_a     = v ^ 16'h5A5A;
        debug_in.alu_in_b     = v + 16'h0100;
        debug_in.alu_out      = v;
        debug_in.dst_reg      = v[4:0];
        debug_in.reg_wr       = v[1:0];
        debug_in.branch_cond  = v[3:0];
        debug_in.fetch_done   = v[0];
        debug_in.status_wr    = v[1];
        debug_in.pc_branch_wr = ~v[0];
    endtask

    task automatic pulse_arm();
        arm = 1'b1; @(negedge clk); arm = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1; @(negedge clk); stop = 1'b0;
    endtask

    task automatic run_dump(input int budget);
        rd_start = 1'b1; @(negedge clk); rd_start = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (tb_state == 3'(IDLE)) break;
            if (rand_ready) dout_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        dout_ready = 1'b1;
        chk("dump_done", 32'(tb_state), 32'(IDLE));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout at %0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0;
        arm = 1'b0; trig = 1'b0; stop = 1'b0; rd_start = 1'b0;
        dout_ready = 1'b1;
        cap_state = WRITE_BACK;
        dbg_idle();
        #12;
        chk("rst_tb_state", 32'(tb_state), 32'd0);
        chk("rst_dout_valid", 32'(dout_valid), 32'd0);
        chk("rst_rec_count", 32'(rec_count), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        chk("rst_dout", 32'(dout), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic capture: three records, stop, dump
        pulse_arm();
        dbg_cap(16'h1111); @(negedge clk);
        dbg_cap(16'h2222); @(negedge clk);
        dbg_cap(16'h3333); @(negedge clk);
        dbg_idle();
        pulse_stop();
        chk("basic_frozen", 32'(tb_state), 32'(FROZEN));
        chk("basic_count", 32'(rec_count), 32'd3);
        got_w.delete(); got_l.delete();
        run_dump(200);
        chk("basic_words", 32'(got_w.size()), 32'd18);
        if (got_w.size() == 18) begin
            chk("basic_w4_0", 32'(got_w[4]), 32'h1111);
            chk("basic_w4_1", 32'(got_w[10]), 32'h2222);
            chk("basic_w4_2", 32'(got_w[16]), 32'h3333);
            chk("basic_last17", 32'(got_l[17]), 32'd1);
            chk("basic_last16", 32'(got_l[16]), 32'd0);
        end
        chk("basic_count_end", 32'(rec_count), 32'd0);

        // Wrap: 20 records into 16 slots
        pulse_arm();
        for (int i = 1; i <= 20; i++) begin
            dbg_cap(16'(i)); @(negedge clk);
        end
        dbg_idle();
        pulse_stop();
        chk("wrap_count", 32'(rec_count), 32'd16);
        chk("wrap_overflow", 32'(overflow), 32'd1);
        got_w.delete(); got_l.delete();
        run_dump(400);
        chk("wrap_words", 32'(got_w.size()), 32'd96);
        for (int k = 0; k < 16; k++) begin
            if (got_w.size() == 96) chk("wrap_w4", 32'(got_w[k * 6 + 4]), 32'(k + 5));
        end

        // Trigger with post-trigger countdown
        pulse_arm();
        for (int i = 1; i <= 10; i++) begin
            dbg_cap(16'(16'h0A00 + i));
            trig = (i == 6);
            @(negedge clk);
        end
        trig = 1'b0;
        chk("trig_frozen", 32'(tb_state), 32'(FROZEN));
        chk("trig_count", 32'(rec_count), 32'd10);
        for (int i = 0; i < 3; i++) begin
            dbg_cap(16'hEEEE); @(negedge clk);
        end
        dbg_idle();
        chk("trig_count_hold", 32'(rec_count), 32'd10);
        got_w.delete(); got_l.delete();
        run_dump(300);
        chk("trig_words", 32'(got_w.size()), 32'd60);
        if (got_w.size() == 60) chk("trig_last_w4", 32'(got_w[58]), 32'h0A0A);

        // Backpressure: sparse captures, random ready during dump
        pulse_arm();
        for (int i = 0; i < 5; i++) begin
            dbg_cap(16'(16'hB000 + i)); @(negedge clk);
            dbg_idle(); repeat (i + 1) @(negedge clk);
        end
        pulse_stop();
        got_w.delete(); got_l.delete();
        rand_ready = 1'b1;
        run_dump(600);
        rand_ready = 1'b0;
        chk("bp_words", 32'(got_w.size()), 32'd30);
        if (got_w.size() == 30) begin
            for (int k = 0; k < 5; k++) begin
                chk("bp_w4", 32'(got_w[k * 6 + 4]), 32'(16'hB000 + k));
                if (k > 0) chk("bp_stamp_incr", 32'(got_w[k * 6] > got_w[(k - 1) * 6]), 32'd1);
            end
        end

        // Empty buffer and ignored inputs
        trig = 1'b1; @(negedge clk); trig = 1'b0;
        chk("idle_trig_ignored", 32'(tb_state), 32'(IDLE));
        pulse_arm();
        pulse_stop();
        chk("empty_frozen", 32'(tb_state), 32'(FROZEN));
        got_w.delete(); got_l.delete();
        rd_start = 1'b1; @(negedge clk); rd_start = 1'b0;
        chk("empty_idle", 32'(tb_state), 32'(IDLE));
        repeat (3) @(negedge clk);
        chk("empty_no_words", 32'(got_w.size()), 32'd0);
        chk("empty_valid", 32'(dout_valid), 32'd0);

        // Reset in the middle of a dump
        pulse_arm();
        for (int i = 0; i < 3; i++) begin
            dbg_cap(16'(16'hC000 + i)); @(negedge clk);
        end
        dbg_idle();
        pulse_stop();
        got_w.delete(); got_l.delete();
        rd_start = 1'b1; @(negedge clk); rd_start = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (got_w.size() >= 7) break;
            @(negedge clk);
        end
        chk("mid_dump_words", 32'(got_w.size()), 32'd7);
        #1 rst_n = 1'b0;
        #1;
        chk("async_rst_valid", 32'(dout_valid), 32'd0);
        chk("async_rst_state", 32'(tb_state), 32'(IDLE));
        chk("async_rst_count", 32'(rec_count), 32'd0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        arm = 1'b1; @(negedge clk); arm = 1'b0;
        dbg_cap(16'hABCD); @(negedge clk);
        dbg_idle();
        pulse_stop();
        got_w.delete(); got_l.delete();
        run_dump(100);
        chk("post_rst_words", 32'(got_w.size()), 32'd6);
        if (got_w.size() == 6) begin
            chk("post_rst_stamp", 32'(got_w[0]), 32'd1);
            chk("post_rst_w4", 32'(got_w[4]), 32'hABCD);
        end

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
